score_bcd_converter: RTL and testbench

SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

---
 rtl/score_bcd_converter_if.sv | 19 +
 rtl/score_bcd_converter.sv | 88 ++++++++
 tb/tb_score_bcd_converter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_converter_if.sv
// Handshake/result bundle for the score-to-BCD converter.
//   start : request a conversion of bin (master -> slave)
//   bin   : unsigned binary score, WIDTH bits (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse, bcd just updated (slave -> master)
//   bcd   : packed BCD result, nibble 0 = ones digit (slave -> master)
interface score_bcd_converter_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) ();
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of score_bcd_converter_if (start/bin in,
//           busy/done/bcd out)
// A conversion takes WIDTH cycles in SHIFT; bcd only changes on the final
// step so the displays never see partial scratch values.
module score_bcd_converter #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  score_bcd_converter_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   count;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_next;

  // Add-3 correction per nibble, then shift in the next binary MSB.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_next = {scratch_adj[BCD_W-2:0], shreg[WIDTH-1]};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            count   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          shreg   <= shreg << 1;
          count   <= count - CNT_W'(1);
          // Last step: publish the finished value and release busy.
          if (count == CNT_W'(1)) begin
            bcd_q  <= scratch_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: directed cases, back-to-back,
// ignored start, mid-conversion reset and an exhaustive sweep, with a queue
// of expected results popped on every done pulse.
module tb_score_bcd_converter;

  localparam int unsigned W = 10;
  localparam int unsigned D = 4;

  logic clock;
  logic reset;

  score_bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus ();

  score_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned      n_checks;
  int unsigned      n_errors;
  logic [4*D-1:0]   exp_q[$];
  logic [4*D-1:0]   last_exp;
  logic             mon_en;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Decimal reference built by repeated division.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(D); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Output monitor: result on done, bcd frozen otherwise.
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.done) begin
        check("done_busy_overlap", 32'(bus.busy), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          check("bcd_result", 32'(bus.bcd), 32'(last_exp));
          for (int i = 0; i < int'(D); i++) begin
            check("nibble_le9", 32'(bus.bcd[4*i +: 4] <= 4'd9), 32'd1);
          end
        end
      end else begin
        check("bcd_hold", 32'(bus.bcd), 32'(last_exp));
      end
    end
  end

  // Count edges until done, also counting cycles seen with busy high.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    for (int i = 0; i < 4 * int'(W); i++) begin
      @(posedge clock); #1;
      edges++;
      if (bus.done) return;
      if (bus.busy) busy_cnt++;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * int'(W); i++) begin
      if (!bus.busy) return;
      @(posedge clock); #1;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  // One conversion with latency and busy-width checks; bin scrambled mid-run.
  task automatic convert(input int v);
    int e, b;
    wait_idle();
    bus.start = 1'b1;
    bus.bin   = W'(v);
    exp_q.push_back(ref_bcd(v));
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(e, b);
    check("latency", 32'(e), 32'(W));
    check("busy_cycles", 32'(b), 32'(W - 1));
  endtask

  initial begin
    int e, b;
    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b0;
    last_exp  = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd",  32'(bus.bcd),  32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed values, first one straight after reset release.
    convert(0);
    convert(1023);
    convert(999);
    convert(9);
    convert(10);

    // Start held high: second request accepted in the done cycle.
    wait_idle();
    bus.start = 1'b1;
    bus.bin   = W'(512);
    exp_q.push_back(ref_bcd(512));
    wait_done(e, b);
    check("b2b_first_edges", 32'(e), 32'(W + 1));
    bus.bin = W'(37);
    exp_q.push_back(ref_bcd(37));
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("b2b_accept_in_done", 32'(bus.busy), 32'd1);
    wait_done(e, b);
    check("b2b_period", 32'(e + 1), 32'(W + 1));

    // Start during busy is ignored.
    wait_idle();
    bus.start = 1'b1;
    bus.bin   = W'(500);
    exp_q.push_back(ref_bcd(500));
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    bus.start = 1'b1;
    bus.bin   = W'(7);
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(e, b);
    repeat (2 * W) @(posedge clock);
    #1;
    check("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Reset on the 5th busy cycle after a result of 42.
    convert(42);
    bus.start = 1'b1;
    bus.bin   = W'(321);
    exp_q.push_back(ref_bcd(321));
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset    = 1'b0;
    last_exp = '0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_bcd",  32'(bus.bcd),  32'd0);
    repeat (2 * W) @(posedge clock);
    #1;
    convert(10);

    // Exhaustive sweep.
    for (int v = 0; v < (1 << W); v++) begin
      convert(v);
    end

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
